// File: rtl/mv_block_sequencer.sv
// rtl/mv_block_sequencer.sv - raster-scans the block grid and presents one motion vector per block.
// Fetches each vector from the MV RAM and holds it until the Reconstructor asks for the next.
module mv_block_sequencer #(
  parameter int BLK_SHIFT = 3,
  parameter int MV_ADDR_W = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           height,
  input  logic [7:0]           width,
  output logic [MV_ADDR_W-1:0] mv_raddr,
  output logic                 mv_re,
  input  logic [15:0]          mv_rdata,
  output logic                 Vector_sig,
  output logic [7:0]           mv_x,
  output logic [7:0]           addr_x,
  output logic [7:0]           mv_y,
  output logic [7:0]           addr_y,
  input  logic                 Nxt_block_sig,
  input  logic                 MVF_complete_sig,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_ADVANCE, S_FLUSH, S_DONE
  } state_t;

  localparam logic [8:0] BLK_ROUND = 9'((1 << BLK_SHIFT) - 1);

  state_t      state_q, state_d;
  logic [8:0]  blocks_x_q, blocks_x_d;
  logic [8:0]  blocks_y_q, blocks_y_d;
  logic [8:0]  bx_q, bx_d;
  logic [8:0]  by_q, by_d;
  logic [7:0]  mv_x_q, mv_x_d;
  logic [7:0]  mv_y_q, mv_y_d;
  logic [7:0]  addr_x_q, addr_x_d;
  logic [7:0]  addr_y_q, addr_y_d;
  logic        frame_done_q, frame_done_d;

  logic [8:0]  blk_w, blk_h;
  logic [8:0]  ax_full, ay_full;
  logic [17:0] lin_addr;
  logic        last_block;
  logic        running;

  // Partial edge blocks round up, so a 20-pixel width yields 3 columns.
  assign blk_w    = ({1'b0, width} + BLK_ROUND) >> BLK_SHIFT;
  assign blk_h    = ({1'b0, height} + BLK_ROUND) >> BLK_SHIFT;
  assign ax_full  = bx_q << BLK_SHIFT;
  assign ay_full  = by_q << BLK_SHIFT;
  assign lin_addr = by_q * blocks_x_q + {9'd0, bx_q};

  assign last_block = (bx_q == blocks_x_q - 9'd1) && (by_q == blocks_y_q - 9'd1);
  assign running    = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      blocks_x_q   <= '0;
      blocks_y_q   <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      addr_x_q     <= '0;
      addr_y_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blocks_x_q   <= blocks_x_d;
      blocks_y_q   <= blocks_y_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      mv_x_q       <= mv_x_d;
      mv_y_q       <= mv_y_d;
      addr_x_q     <= addr_x_d;
      addr_y_q     <= addr_y_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    blocks_x_d   = blocks_x_q;
    blocks_y_d   = blocks_y_q;
    bx_d         = bx_q;
    by_d         = by_q;
    mv_x_d       = mv_x_q;
    mv_y_d       = mv_y_q;
    addr_x_d     = addr_x_q;
    addr_y_d     = addr_y_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          blocks_x_d = blk_w;
          blocks_y_d = blk_h;
          bx_d       = '0;
          by_d       = '0;
          if (blk_w == 9'd0 || blk_h == 9'd0) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        mv_x_d   = mv_rdata[7:0];
        mv_y_d   = mv_rdata[15:8];
        addr_x_d = ax_full[7:0];
        addr_y_d = ay_full[7:0];
        state_d  = S_PRESENT;
      end
      S_PRESENT: begin
        if (Nxt_block_sig) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (bx_q < blocks_x_q - 9'd1) begin
          bx_d = bx_q + 9'd1;
        end else begin
          bx_d = '0;
          by_d = by_q + 9'd1;
        end
        state_d = last_block ? S_FLUSH : S_FETCH;
      end
      S_FLUSH: begin
        if (MVF_complete_sig) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable mid-run abandons the frame silently and blanks the vector outputs.
    if (running && !enable) begin
      state_d      = S_IDLE;
      frame_done_d = 1'b0;
      mv_x_d       = '0;
      mv_y_d       = '0;
      addr_x_d     = '0;
      addr_y_d     = '0;
    end
  end

  assign mv_re      = (state_q == S_FETCH);
  assign mv_raddr   = (state_q == S_FETCH) ? MV_ADDR_W'(lin_addr) : '0;
  assign Vector_sig = (state_q == S_PRESENT);
  assign busy       = running;
  assign frame_done = frame_done_q;
  assign mv_x       = mv_x_q;
  assign mv_y       = mv_y_q;
  assign addr_x     = addr_x_q;
  assign addr_y     = addr_y_q;

endmodule

// File: doc/mv_block_sequencer.md
Name: mv_block_sequencer

Overview:
- Transmit-side counterpart of the Reconstructor's vector input.
- Raster-scans the block grid of one frame and fetches each block's motion vector from the MV RAM.
- Presents each vector on the Vector_sig / mv_x / addr_x / mv_y / addr_y interface and holds it until the Reconstructor requests the next block with Nxt_block_sig.
- After the last block it waits for MVF_complete_sig and then reports frame completion.

Parameters:
- BLK_SHIFT, 3: log2 of the block edge in pixels (3 gives 8x8 blocks).
- MV_ADDR_W, 16: width of the MV RAM address.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- enable  input  1  level; high requests and holds a frame run.
- height  input  8  frame height in pixels.
- width  input  8  frame width in pixels.
- mv_raddr  output  MV_ADDR_W  MV RAM read address.
- mv_re  output  1  MV RAM read strobe.
- mv_rdata  input  16  RAM data, valid exactly 1 cycle after mv_re; [15:8] is mv_y, [7:0] is mv_x.
- Vector_sig  output  1  vector valid.
- mv_x  output  8  horizontal motion vector.
- addr_x  output  8  block top-left x in pixels.
- mv_y  output  8  vertical motion vector.
- addr_y  output  8  block top-left y in pixels.
- Nxt_block_sig  input  1  Reconstructor accepts the current vector and requests the next.
- MVF_complete_sig  input  1  Reconstructor has finished writing the motion vector field.
- busy  output  1  high in any state other than IDLE and DONE.
- frame_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset value of every output is 0.
- Grid size:
  - blocks_x = (width + 2^BLK_SHIFT - 1) >> BLK_SHIFT, computed in 9 bits; partial edge blocks are included.
  - blocks_y is computed the same way from height.
- Addressing:
  - mv_raddr = by*blocks_x + bx, truncated to MV_ADDR_W.
  - addr_x = bx << BLK_SHIFT and addr_y = by << BLK_SHIFT, both truncated to 8 bits.
- FSM states: IDLE, FETCH, WAIT, PRESENT, ADVANCE, FLUSH, DONE.
  - IDLE: if enable=1, latch width/height and compute blocks_x and blocks_y. If either is 0, go to DONE with a frame_done pulse. Otherwise set bx=by=0 and go to FETCH.
  - FETCH (1 cycle): mv_re=1 and mv_raddr is valid. Go to WAIT.
  - WAIT (1 cycle): capture mv_rdata into mv_x/mv_y and capture addr_x/addr_y. Go to PRESENT.
  - PRESENT: Vector_sig=1 and all data outputs are stable. Stay until Nxt_block_sig=1 is sampled; then deassert Vector_sig on the next edge and go to ADVANCE.
  - ADVANCE: if bx<blocks_x-1, increment bx. Otherwise set bx=0 and increment by. If the last block was just accepted (bx=blocks_x-1 and by=blocks_y-1), go to FLUSH; otherwise go to FETCH.
  - FLUSH: wait for MVF_complete_sig=1, then pulse frame_done for 1 cycle and go to DONE.
  - DONE: outputs idle. Return to IDLE only once enable=0, so a held-high enable runs exactly one frame.
- Nxt_block_sig outside PRESENT is ignored; it is never counted as an accept.
- MVF_complete_sig outside FLUSH is ignored.
- Nxt_block_sig in the same cycle Vector_sig first rises is a valid accept, giving a minimum of 4 cycles per block.
- enable=0 in any state from FETCH through FLUSH aborts the run:
  - next edge goes to IDLE with Vector_sig=0 and mv_re=0;
  - no frame_done pulse;
  - mv_x, mv_y, addr_x and addr_y are cleared.
- Asynchronous reset mid-frame clears state and outputs immediately, without waiting for a clock edge.
- width and height changes during a run have no effect, because they were latched in IDLE.
- Maximum grid is 32x32 blocks with BLK_SHIFT=3, so mv_raddr needs at most 10 bits.

Test Plan:
- width=16, height=16, BLK_SHIFT=3, Nxt_block_sig pulsed 1 cycle after each Vector_sig rise -> 4 vectors with (addr_x,addr_y) = (0,0),(8,0),(0,8),(8,8), mv_raddr 0,1,2,3, mv_x/mv_y equal to the RAM contents. After MVF_complete_sig -> one frame_done pulse, busy=0.
- width=20, height=8 -> 3 blocks with addr_x 0, 8, 16 and addr_y=0; mv_raddr 0, 1, 2.
- Backpressure: Nxt_block_sig withheld 7 cycles -> Vector_sig and all data outputs held constant for 7+ cycles, mv_re stays 0, and the next fetch starts only after the accept.
- width=0, height=16 -> no mv_re and no Vector_sig; frame_done pulses on the edge after enable rises; stays in DONE until enable falls.
- Abort and reset:
  - enable dropped while in PRESENT on block 2 -> next edge Vector_sig=0, no frame_done.
  - Re-raising enable -> restarts at addr (0,0).
  - reset asserted between edges -> all outputs 0 immediately.
- Nxt_block_sig stuck high throughout a 16x16 frame -> exactly 4 accepts, one per PRESENT entry. FLUSH waits for MVF_complete_sig regardless; a MVF_complete_sig pulse sent earlier in the frame has no effect.
